i2c_bus_arbiter: RTL and testbench
==================================

I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, number of I2C requesters (2..8).
REQ-002 SHALL have parameter GuardCycles, default 64, bus-free idle cycles required between ownerships (1..65535).
REQ-003 SHALL have parameter TimeoutCycles, default 1000000, maximum ownership cycles; 0 disables timeout.
REQ-004 SHALL have port ipClk, input, 1, sole clock, all logic rising-edge.
REQ-005 SHALL have port ipReset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port ipRequest, input, N, per-client bus request, level-held for the whole transaction.
REQ-007 SHALL have port opGrant, output, N, per-client grant, one-hot or zero.
REQ-008 SHALL have port ipClientSClk, input, N, per-client SCL drive (0 = pull low, 1 = release).
REQ-009 SHALL have port ipClientData, input, N, per-client SDA drive (0 = pull low, 1 = release).
REQ-010 SHALL have port opI2C_SClk, output, 1, SCL drive to pad (0 = pull low, 1 = release).
REQ-011 SHALL have port opI2C_Data, output, 1, SDA drive to pad (0 = pull low, 1 = release).
REQ-012 SHALL have port ipI2C_SClk, input, 1, SCL pad readback.
REQ-013 SHALL have port ipI2C_Data, input, 1, SDA pad readback.
REQ-014 SHALL have port opBusy, output, 1, high when any grant is active or in GUARD.
REQ-015 SHALL have port opTimeout, output, 1, single-cycle pulse on ownership revocation.

Function
REQ-016 SHALL implement states IDLE, GRANTED, GUARD.
REQ-017 In IDLE with any unmasked request high at edge k, SHALL assert opGrant for one client at edge k+1 and enter GRANTED.
REQ-018 Selection SHALL be round-robin: search starts at (last granted index + 1) mod N, wrapping.
REQ-019 In GRANTED, opI2C_SClk/opI2C_Data SHALL equal ipClientSClk/ipClientData of the granted client combinationally; other clients' drives ignored.
REQ-020 Outside GRANTED, opI2C_SClk and opI2C_Data SHALL be 1.
REQ-021 When the granted client's request is low at an edge, opGrant SHALL clear at that edge and the state SHALL become GUARD.
REQ-022 In GUARD, a counter SHALL increment on each cycle with ipI2C_SClk=1 and ipI2C_Data=1, clear to 0 on any cycle with either low; reaching GuardCycles SHALL move to IDLE.
REQ-023 Requests arriving during GRANTED or GUARD SHALL wait; no pre-emption by requests.
REQ-024 In GRANTED with TimeoutCycles>0, an ownership counter SHALL count cycles from grant; at count = TimeoutCycles the grant SHALL clear, opTimeout SHALL pulse one cycle, state SHALL become GUARD.
REQ-025 A timed-out client SHALL be masked from arbitration until its request is observed low, then unmasked.
REQ-026 Request drop and timeout on the same edge SHALL be a normal release: no opTimeout pulse, no mask.
REQ-027 opBusy SHALL be high in GRANTED and GUARD, low in IDLE.
REQ-028 Round-robin pointer SHALL update to the granted index on each new grant.
REQ-029 Counter widths SHALL cover their parameter maxima without wrap; counters SHALL saturate, never wrap.

Reset
REQ-030 ipReset high SHALL immediately force: state IDLE, opGrant=0, opI2C_SClk=1, opI2C_Data=1, opBusy=0, opTimeout=0, counters 0, mask 0, pointer such that client 0 has first priority.
REQ-031 Reset asserted mid-transaction SHALL release the bus in the same cycle, no GUARD wait after deassertion.

Verification
REQ-032 N=4, reset released, ipRequest=4'b0101 -> opGrant=4'b0001 one cycle later; client 0 SCL/SDA drive visible on pad outputs.
REQ-033 Client 0 drops request, bus readback high -> opGrant=0, opBusy=1 for exactly GuardCycles=64 cycles, then opGrant=4'b0100.
REQ-034 During GUARD, ipI2C_Data held low 10 cycles at count 30 -> IDLE reached 64 high cycles after release of SDA, not earlier.
REQ-035 TimeoutCycles=100, client 1 holds request -> opGrant clears at cycle 100, opTimeout one-cycle pulse, client 1 not regranted until its request toggles low.
REQ-036 All four requesting continuously, each releasing after 20 cycles -> grant order 0,1,2,3,0; never two grant bits high.
REQ-037 ipReset pulsed while client 2 granted and driving SDA=0 -> opGrant=0 and opI2C_Data=1 in the same cycle, opBusy=0.

Source files
------------

// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter
//   Shares one I2C bus (SCL/SDA open-drain pad drives) among N requesters.
//   A free bus is granted round-robin to one requester. The owner's SCL/SDA
//   drives pass straight through to the pad. After the owner lets go, the bus
//   must read back idle (both lines high) for GuardCycles consecutive cycles
//   before the next grant. An owner that holds the bus for TimeoutCycles is
//   revoked and kept out of arbitration until it drops its request.
//
// Ports
//   ipClk          sole clock, rising edge
//   ipReset        asynchronous active-high reset
//   ipRequest[N]   per-client request, held high for the whole transaction
//   opGrant[N]     per-client grant, one-hot or zero (registered)
//   ipClientSClk   per-client SCL drive (0 = pull low, 1 = release)
//   ipClientData   per-client SDA drive (0 = pull low, 1 = release)
//   opI2C_SClk     SCL drive to pad (owner's drive while granted, else 1)
//   opI2C_Data     SDA drive to pad (owner's drive while granted, else 1)
//   ipI2C_SClk     SCL pad readback
//   ipI2C_Data     SDA pad readback
//   opBusy         high while a grant is active or the guard interval runs
//   opTimeout      one-cycle pulse when an ownership is revoked
module i2c_bus_arbiter #(
  parameter int N             = 4,
  parameter int GuardCycles   = 64,
  parameter int TimeoutCycles = 1000000
) (
  input  logic         ipClk,
  input  logic         ipReset,
  input  logic [N-1:0] ipRequest,
  output logic [N-1:0] opGrant,
  input  logic [N-1:0] ipClientSClk,
  input  logic [N-1:0] ipClientData,
  output logic         opI2C_SClk,
  output logic         opI2C_Data,
  input  logic         ipI2C_SClk,
  input  logic         ipI2C_Data,
  output logic         opBusy,
  output logic         opTimeout
);

  localparam int IdxW   = (N > 1) ? $clog2(N) : 1;
  localparam int GuardW = $clog2(GuardCycles + 1);
  localparam int OwnW   = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    GUARD   = 2'd2
  } state_t;

  state_t              state_r;
  logic [IdxW-1:0]     ptr_r;         // current owner while granted, else last owner
  logic [N-1:0]        mask_r;        // clients barred after a timeout
  logic [GuardW-1:0]   guardCount_r;
  logic [OwnW-1:0]     ownCount_r;

  logic [N-1:0]        eligible_s;
  logic [IdxW:0]       pick_s;        // {found, index}
  logic                ownerReq_s;
  logic                busIdle_s;
  logic [GuardW-1:0]   guardNext_s;
  logic [OwnW-1:0]     ownNext_s;
  logic                timeoutHit_s;
  logic [N-1:0]        maskKeep_s;
  logic [N-1:0]        ownerOneHot_s;

  // Round-robin search starting just after 'last'. Walking the candidates
  // from farthest to nearest and overwriting leaves the nearest match.
  function automatic logic [IdxW:0] pickNext(input logic [N-1:0] eligible,
                                             input logic [IdxW-1:0] last);
    logic [IdxW:0]   result;
    logic [IdxW-1:0] candIdx;
    int              cand;
    result = '0;
    for (int k = N; k >= 1; k--) begin
      cand    = (int'(last) + k) % N;
      candIdx = cand[IdxW-1:0];
      result  = eligible[candIdx] ? {1'b1, candIdx} : result;
    end
    return result;
  endfunction

  function automatic logic [N-1:0] toOneHot(input logic [IdxW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign eligible_s    = ipRequest & ~mask_r;
  assign pick_s        = pickNext(eligible_s, ptr_r);
  assign ownerReq_s    = ipRequest[ptr_r];
  assign busIdle_s     = ipI2C_SClk & ipI2C_Data;
  assign ownerOneHot_s = toOneHot(ptr_r);
  // A barred client is released as soon as its request is seen low.
  assign maskKeep_s    = mask_r & ipRequest;

  // Both counters saturate at their limit instead of wrapping.
  assign guardNext_s  = (guardCount_r >= GuardW'(GuardCycles)) ? guardCount_r
                                                               : guardCount_r + GuardW'(1);
  assign ownNext_s    = (ownCount_r >= OwnW'(TimeoutCycles)) ? ownCount_r
                                                             : ownCount_r + OwnW'(1);
  assign timeoutHit_s = (TimeoutCycles > 0) && (ownNext_s == OwnW'(TimeoutCycles));

  // Pad drive follows the owner only while granted; otherwise both lines released.
  always_comb begin
    opI2C_SClk = 1'b1;
    opI2C_Data = 1'b1;
    if (state_r == GRANTED) begin
      opI2C_SClk = ipClientSClk[ptr_r];
      opI2C_Data = ipClientData[ptr_r];
    end else begin
      opI2C_SClk = 1'b1;
      opI2C_Data = 1'b1;
    end
  end

  // Arbitration FSM with registered grant, busy and timeout outputs.
  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state_r      <= IDLE;
      opGrant      <= '0;
      opBusy       <= 1'b0;
      opTimeout    <= 1'b0;
      guardCount_r <= '0;
      ownCount_r   <= '0;
      mask_r       <= '0;
      ptr_r        <= IdxW'(N - 1);  // search then starts at client 0
    end else begin
      opTimeout <= 1'b0;
      mask_r    <= maskKeep_s;
      case (state_r)
        IDLE: begin
          if (pick_s[IdxW]) begin
            state_r    <= GRANTED;
            ptr_r      <= pick_s[IdxW-1:0];
            opGrant    <= toOneHot(pick_s[IdxW-1:0]);
            opBusy     <= 1'b1;
            ownCount_r <= '0;
          end else begin
            opBusy <= 1'b0;
          end
        end
        GRANTED: begin
          // A request drop wins over a coincident timeout: normal release.
          if (!ownerReq_s) begin
            state_r      <= GUARD;
            opGrant      <= '0;
            guardCount_r <= '0;
          end else if (timeoutHit_s) begin
            state_r      <= GUARD;
            opGrant      <= '0;
            opTimeout    <= 1'b1;
            mask_r       <= maskKeep_s | ownerOneHot_s;
            guardCount_r <= '0;
          end else begin
            ownCount_r <= ownNext_s;
          end
        end
        GUARD: begin
          // Any low line on the readback restarts the idle run.
          if (busIdle_s) begin
            if (guardNext_s == GuardW'(GuardCycles)) begin
              state_r      <= IDLE;
              opBusy       <= 1'b0;
              guardCount_r <= '0;
            end else begin
              guardCount_r <= guardNext_s;
            end
          end else begin
            guardCount_r <= '0;
          end
        end
        default: begin
          state_r <= IDLE;
          opGrant <= '0;
          opBusy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Testbench for i2c_bus_arbiter (N=4, GuardCycles=64, TimeoutCycles=100).
// Directed scenarios with literal expectations, then randomized traffic.
// A bench-side ownership model (owner index, guard run length, hold time,
// barred set) predicts every output; a negedge process compares each cycle.
module tb_i2c_bus_arbiter;
  localparam int N  = 4;
  localparam int GC = 64;
  localparam int TO = 100;

  logic         ipClk = 1'b0;
  logic         ipReset = 1'b1;
  logic [N-1:0] ipRequest = '0;
  logic [N-1:0] ipClientSClk = '1;
  logic [N-1:0] ipClientData = '1;
  logic         ipI2C_SClk = 1'b1;
  logic         ipI2C_Data = 1'b1;
  logic [N-1:0] opGrant;
  logic         opI2C_SClk, opI2C_Data, opBusy, opTimeout;

  int nChecks = 0;
  int nPass = 0;
  bit cmpOn = 1'b0;

  // Reference model state
  int           mOwner;    // -1 when nobody owns the bus
  bit           mGuard;    // waiting for an idle bus run
  int           mQuiet;    // consecutive idle readback cycles
  int           mHeld;     // cycles since the current grant
  int           mLast;     // last granted client
  bit [N-1:0]   mBlocked;  // clients barred after timeout
  bit           mPulse;

  i2c_bus_arbiter #(.N(N), .GuardCycles(GC), .TimeoutCycles(TO)) dut (
    .ipClk(ipClk), .ipReset(ipReset), .ipRequest(ipRequest), .opGrant(opGrant),
    .ipClientSClk(ipClientSClk), .ipClientData(ipClientData),
    .opI2C_SClk(opI2C_SClk), .opI2C_Data(opI2C_Data),
    .ipI2C_SClk(ipI2C_SClk), .ipI2C_Data(ipI2C_Data),
    .opBusy(opBusy), .opTimeout(opTimeout)
  );

  always #5 ipClk = ~ipClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic modelReset();
    mOwner = -1; mGuard = 1'b0; mQuiet = 0; mHeld = 0;
    mLast = N - 1; mBlocked = '0; mPulse = 1'b0;
  endtask

  function automatic int pickModel();
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (mLast + k) % N;
      if (ipRequest[c] && !mBlocked[c]) return c;
    end
    return -1;
  endfunction

  // One clock edge of the ownership rules, using the inputs seen at that edge.
  task automatic modelStep();
    int pick;
    mPulse = 1'b0;
    if (ipReset) begin
      modelReset();
      return;
    end
    pick = pickModel();
    for (int i = 0; i < N; i++) if (!ipRequest[i]) mBlocked[i] = 1'b0;
    if (mOwner < 0 && !mGuard) begin
      if (pick >= 0) begin
        mOwner = pick; mLast = pick; mHeld = 0;
      end
    end else if (mOwner >= 0) begin
      if (!ipRequest[mOwner]) begin
        mOwner = -1; mGuard = 1'b1; mQuiet = 0;
      end else begin
        mHeld++;
        if (TO > 0 && mHeld >= TO) begin
          mBlocked[mOwner] = 1'b1; mPulse = 1'b1;
          mOwner = -1; mGuard = 1'b1; mQuiet = 0;
        end
      end
    end else begin
      if (ipI2C_SClk && ipI2C_Data) mQuiet++;
      else mQuiet = 0;
      if (mQuiet >= GC) mGuard = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge ipClk);
    modelStep();
    #1;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge ipClk) begin
    logic [N-1:0] eg;
    if (cmpOn) begin
      eg = '0;
      if (mOwner >= 0) eg[mOwner] = 1'b1;
      check("grant", opGrant, eg);
      check("busy", opBusy, (mOwner >= 0) || mGuard);
      check("timeout", opTimeout, mPulse);
      check("scl", opI2C_SClk, (mOwner >= 0) ? ipClientSClk[mOwner] : 1'b1);
      check("sda", opI2C_Data, (mOwner >= 0) ? ipClientData[mOwner] : 1'b1);
      check("onehot", $countones(opGrant) <= 1, 1);
    end
  end

  initial begin
    int n;
    bit done;
    int idx;
    int expOrder[5];
    expOrder = '{0, 1, 2, 3, 0};
    modelReset();
    repeat (2) tick();
    check("rst grant", opGrant, 4'b0000);
    check("rst busy", opBusy, 1'b0);
    check("rst timeout", opTimeout, 1'b0);
    check("rst scl", opI2C_SClk, 1'b1);
    check("rst sda", opI2C_Data, 1'b1);
    cmpOn = 1'b1;
    ipReset = 1'b0;
    tick();

    // First grant goes to client 0; its drives reach the pad, others ignored.
    ipRequest = 4'b0101; ipClientSClk = 4'b1110; ipClientData = 4'b0001;
    tick();
    check("first grant", opGrant, 4'b0001);
    check("pass scl", opI2C_SClk, 1'b0);
    check("pass sda", opI2C_Data, 1'b1);
    ipClientSClk = 4'b0001; ipClientData = 4'b1110;
    #1;
    check("comb scl", opI2C_SClk, 1'b1);
    check("comb sda", opI2C_Data, 1'b0);
    repeat (5) tick();

    // Release: exactly GC busy cycles without a grant, then client 2.
    ipRequest = 4'b0100; ipClientSClk = '1; ipClientData = '1;
    tick();
    check("release grant", opGrant, 4'b0000);
    n = 1; done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      tick();
      if (opBusy) n++;
      else done = 1'b1;
    end
    check("guard length", n, 64);
    tick();
    check("second grant", opGrant, 4'b0100);

    // Reset while client 2 pulls SDA low: bus released at once, no guard after.
    ipClientData = 4'b1011;
    #1;
    check("owner sda", opI2C_Data, 1'b0);
    ipReset = 1'b1;
    modelReset();
    #1;
    check("async grant", opGrant, 4'b0000);
    check("async sda", opI2C_Data, 1'b1);
    check("async busy", opBusy, 1'b0);
    tick();
    ipReset = 1'b0;
    tick();
    check("regrant after reset", opGrant, 4'b0100);

    // Guard restarts when SDA reads low partway through.
    ipRequest = 4'b0000; ipClientData = '1;
    tick();
    repeat (30) tick();
    ipI2C_Data = 1'b0;
    repeat (10) tick();
    check("guard held", opBusy, 1'b1);
    ipI2C_Data = 1'b1;
    n = 0; done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      tick();
      n++;
      if (!opBusy) done = 1'b1;
    end
    check("guard restart", n, 64);

    // Timeout after TO cycles, then barred until the request drops.
    ipRequest = 4'b0010;
    tick();
    check("to grant", opGrant, 4'b0010);
    n = 0; done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      tick();
      n++;
      if (opGrant == 4'b0000) done = 1'b1;
    end
    check("to length", n, 100);
    check("to pulse", opTimeout, 1'b1);
    tick();
    check("to pulse end", opTimeout, 1'b0);
    repeat (100) tick();
    check("to barred", opGrant, 4'b0000);
    ipRequest = 4'b0000;
    tick();
    ipRequest = 4'b0010;
    tick();
    check("to unbarred", opGrant, 4'b0010);
    ipRequest = 4'b0000;
    tick();
    repeat (70) tick();

    // Round-robin order with everyone requesting.
    ipReset = 1'b1;
    modelReset();
    tick();
    ipReset = 1'b0;
    tick();
    ipRequest = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int t = 0; t < 200 && opGrant == 4'b0000; t++) tick();
      check("rr wait", opGrant != 4'b0000, 1);
      idx = -1;
      for (int b = 0; b < N; b++) if (opGrant[b]) idx = b;
      check("rr order", idx, expOrder[g]);
      if (idx >= 0) begin
        repeat (20) tick();
        ipRequest[idx] = 1'b0;
        tick();
        ipRequest[idx] = 1'b1;
      end
    end
    ipRequest = 4'b0000;
    repeat (70) tick();

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 8000; cyc++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(39) == 0) ipRequest[i] = ~ipRequest[i];
      ipClientSClk = N'($urandom);
      ipClientData = N'($urandom);
      ipI2C_SClk = ($urandom_range(199) != 0);
      ipI2C_Data = ($urandom_range(199) != 0);
      if ($urandom_range(799) == 0) begin
        ipReset = 1'b1;
        modelReset();
      end else begin
        ipReset = 1'b0;
      end
      tick();
    end
    ipReset = 1'b0;
    tick();
    cmpOn = 1'b0;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
